// File: rtl/wb_regfile.sv
// Write-back register file (r0 hard-wired to zero) with same-cycle write bypass
// on every read path, plus a ready/valid debug dump of r0..r[DUMP_LAST].
module wb_regfile #(
  parameter int DUMP_LAST = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_WREG,
  input  logic [4:0]  wb_td,
  input  logic [31:0] wb_memdata,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        dbg_start,
  input  logic        dbg_ready,
  output logic        dbg_valid,
  output logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic        dbg_busy,
  output logic        dbg_done
);

  localparam logic [4:0] LAST = 5'(DUMP_LAST);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t      state_q;
  logic [4:0]  ptr_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] regs_q [1:31];

  // r0 is never stored; a write in flight is forwarded so readers see it this cycle
  function automatic logic [31:0] rd(input logic [4:0] a);
    if (a == 5'd0)
      return 32'd0;
    else if (wb_WREG && (wb_td == a))
      return wb_memdata;
    else
      return regs_q[a];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++)
        regs_q[i] <= 32'd0;
    end else if (wb_WREG && (wb_td != 5'd0)) begin
      regs_q[wb_td] <= wb_memdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 5'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dbg_start) begin
            state_q <= SEND;
            ptr_q   <= 5'd0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SEND: begin
          if (dbg_ready) begin
            if (ptr_q >= LAST) begin
              state_q <= DONE;
              ptr_q   <= 5'd0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              ptr_q <= ptr_q + 5'd1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ptr_q   <= 5'd0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rs_data   = rd(rs_addr);
    rt_data   = rd(rt_addr);
    dbg_valid = valid_q;
    dbg_addr  = valid_q ? ptr_q : 5'd0;
    dbg_data  = valid_q ? rd(ptr_q) : 32'd0;
    dbg_busy  = busy_q;
    dbg_done  = done_q;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: bypass reads, r0 handling, full dumps with
// stalls and mid-dump writes, asynchronous reset abort, and a one-beat dump.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_WREG;
  logic [4:0]  wb_td;
  logic [31:0] wb_memdata;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic        dbg_start, dbg_ready;
  logic        dbg_valid, dbg_busy, dbg_done;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  logic        s0_start, s0_ready;
  logic [31:0] rs0, rt0, d0_data;
  logic        v0, b0, dn0;
  logic [4:0]  a0;

  logic [31:0] model [32];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  wb_regfile #(.DUMP_LAST(31)) dut (
    .clk(clk), .rst(rst), .wb_WREG(wb_WREG), .wb_td(wb_td), .wb_memdata(wb_memdata),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .dbg_start(dbg_start), .dbg_ready(dbg_ready), .dbg_valid(dbg_valid),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_busy(dbg_busy), .dbg_done(dbg_done)
  );

  wb_regfile #(.DUMP_LAST(0)) dut0 (
    .clk(clk), .rst(rst), .wb_WREG(wb_WREG), .wb_td(wb_td), .wb_memdata(wb_memdata),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs0), .rt_data(rt0),
    .dbg_start(s0_start), .dbg_ready(s0_ready), .dbg_valid(v0),
    .dbg_addr(a0), .dbg_data(d0_data), .dbg_busy(b0), .dbg_done(dn0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // inputs change 1 ns after the rising edge; checks follow 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_WREG = 1'b1; wb_td = a; wb_memdata = d;
    step();
    wb_WREG = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  // full dump of r0..r31; optional stall at stall_addr and a write landing on wr_addr's beat
  task automatic run_dump(input int stall_addr, input int stall_len, input int wr_addr);
    int exp_addr = 0;
    int stalls   = 0;
    int busy_cnt = 0;
    int beats    = 0;
    dbg_start = 1'b1; dbg_ready = 1'b1;
    step();
    for (int cyc = 0; cyc < 80 && beats < 32; cyc++) begin
      dbg_start = (exp_addr < 3);
      dbg_ready = !((exp_addr == stall_addr) && (stalls < stall_len));
      if (exp_addr == wr_addr) begin
        wb_WREG = 1'b1; wb_td = 5'(wr_addr); wb_memdata = 32'h7777_0000 | wr_addr;
        model[wr_addr] = wb_memdata;
      end
      #1;
      chk("dump_valid", {31'd0, dbg_valid}, 32'd1);
      chk("dump_addr", {27'd0, dbg_addr}, exp_addr);
      chk("dump_data", dbg_data, model[exp_addr]);
      chk("dump_done_low", {31'd0, dbg_done}, 32'd0);
      if (dbg_busy) busy_cnt++;
      if (dbg_ready) begin exp_addr++; beats++; end
      else stalls++;
      @(posedge clk); #1;
      wb_WREG = 1'b0;
    end
    dbg_start = 1'b0;
    chk("dump_beats", beats, 32);
    chk("dump_stalls", stalls, stall_len);
    #1;
    chk("dump_done_pulse", {31'd0, dbg_done}, 32'd1);
    chk("dump_valid_off", {31'd0, dbg_valid}, 32'd0);
    chk("dump_addr_off", {27'd0, dbg_addr}, 32'd0);
    chk("dump_data_off", dbg_data, 32'd0);
    if (dbg_busy) busy_cnt++;
    chk("dump_busy_cycles", busy_cnt, 33 + stall_len);
    step();
    chk("dump_done_end", {31'd0, dbg_done}, 32'd0);
    chk("dump_busy_end", {31'd0, dbg_busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; wb_WREG = 1'b0; wb_td = '0; wb_memdata = '0;
    rs_addr = 5'd5; rt_addr = 5'd6;
    dbg_start = 1'b0; dbg_ready = 1'b0; s0_start = 1'b0; s0_ready = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    #1;
    chk("rst_valid", {31'd0, dbg_valid}, 32'd0);
    chk("rst_busy", {31'd0, dbg_busy}, 32'd0);
    chk("rst_done", {31'd0, dbg_done}, 32'd0);
    chk("rst_rs", rs_data, 32'd0);
    #11 rst = 1'b0;
    step();

    // write then read back, with same-cycle bypass
    wb_WREG = 1'b1; wb_td = 5'd5; wb_memdata = 32'hDEADBEEF;
    #1 chk("bypass_r5", rs_data, 32'hDEADBEEF);
    step();
    wb_WREG = 1'b0; model[5] = 32'hDEADBEEF;
    #1;
    chk("r5_stored", rs_data, 32'hDEADBEEF);
    chk("r6_zero", rt_data, 32'd0);

    // disabled write must not land
    wb_td = 5'd5; wb_memdata = 32'h0BAD0BAD;
    step();
    chk("no_write_wreg0", rs_data, 32'hDEADBEEF);

    // r0 never written
    rs_addr = 5'd0; wb_WREG = 1'b1; wb_td = 5'd0; wb_memdata = 32'h12345678;
    #1 chk("r0_before", rs_data, 32'd0);
    step();
    wb_WREG = 1'b0;
    #1 chk("r0_after", rs_data, 32'd0);

    // bypass on both ports over an older value
    wr(5'd9, 32'h1);
    rs_addr = 5'd9; rt_addr = 5'd9;
    #1 chk("r9_old", rs_data, 32'h1);
    wb_WREG = 1'b1; wb_td = 5'd9; wb_memdata = 32'hA5A5A5A5;
    #1;
    chk("bypass_rs9", rs_data, 32'hA5A5A5A5);
    chk("bypass_rt9", rt_data, 32'hA5A5A5A5);
    step();
    wb_WREG = 1'b0; model[9] = 32'hA5A5A5A5;
    #1 chk("r9_stored", rt_data, 32'hA5A5A5A5);

    // single-beat dump on the DUMP_LAST=0 instance
    s0_start = 1'b1; s0_ready = 1'b1;
    step();
    s0_start = 1'b0;
    chk("d0_valid", {31'd0, v0}, 32'd1);
    chk("d0_addr", {27'd0, a0}, 32'd0);
    chk("d0_data", d0_data, 32'd0);
    step();
    chk("d0_done", {31'd0, dn0}, 32'd1);
    chk("d0_valid_off", {31'd0, v0}, 32'd0);
    step();
    chk("d0_idle", {31'd0, b0 | dn0}, 32'd0);

    for (int i = 1; i < 32; i++) wr(5'(i), 32'hC0DE_0000 | i);
    run_dump(-1, 0, 7);
    run_dump(4, 3, -1);

    // reset mid-dump at beat 10
    dbg_start = 1'b1; dbg_ready = 1'b1;
    step();
    dbg_start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("abort_addr", {27'd0, dbg_addr}, 32'd10);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", {31'd0, dbg_valid}, 32'd0);
    chk("abort_busy", {31'd0, dbg_busy}, 32'd0);
    rs_addr = 5'd5; rt_addr = 5'd31;
    #1;
    chk("abort_rs", rs_data, 32'd0);
    chk("abort_rt", rt_data, 32'd0);
    step(); step();
    chk("abort_no_done", {31'd0, dbg_done}, 32'd0);
    #3 rst = 1'b0;
    wb_WREG = 1'b1; wb_td = 5'd3; wb_memdata = 32'h33;
    step();
    wb_WREG = 1'b0; rs_addr = 5'd3;
    #1;
    chk("post_rst_write", rs_data, 32'h33);
    chk("post_rst_done", {31'd0, dbg_done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
